// File: rtl/instr_mem_loader_pkg.sv
// Shared types and helpers for the runtime-loadable instruction memory.
// Holds no logic of its own.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [7:0] NOP_DEFAULT = 8'h00;

  // Width able to hold any count from 0 to depth inclusive.
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Load stream and CPU fetch bundle; master drives load beats and pc, slave is the loader.
// Valid/ready on the load side; the fetch side has no handshake.
interface instr_mem_loader_if #(
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 6
);
  logic               load_start;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               load_ready;
  logic               load_done;
  logic               load_ovf;
  logic               cpu_run;
  logic [LEN_W-1:0]   prog_len;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_oob;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_addr,
    input  load_ready, load_done, load_ovf, cpu_run, prog_len, fetch_instr, fetch_oob
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_addr,
    output load_ready, load_done, load_ovf, cpu_run, prog_len, fetch_instr, fetch_oob
  );
endinterface

// File: rtl/instr_mem_array.sv
// DEPTH x INSTR_W storage: one synchronous write port, one asynchronous read port, no reset.
// Zero-cycle read latency; the caller gates out-of-range reads.
module instr_mem_array #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 32,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_mem_loader.sv
// Runtime-loadable program memory: loads a byte stream, holds the CPU until done, then serves fetches.
// Fetch is combinational; load_ready is high only in LOAD, so beats stall on load_valid alone.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int                 INSTR_W  = 8,
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_DEFAULT)
) (
  input  logic               clk_50m,
  input  logic               reset,
  instr_mem_loader_if.slave  bus
);

  localparam int LEN_W = len_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CMP_W = max_int(ADDR_W, LEN_W);

  state_t             state_q;
  state_t             state_d;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [LEN_W-1:0]   prog_len_q;
  logic               load_done_q;
  logic               load_ovf_q;
  logic               cpu_run_q;
  logic               load_ready;
  logic               start_load;
  logic               beat;
  logic               ptr_at_end;
  logic               exit_load;
  logic               in_range;
  logic [INSTR_W-1:0] rd_data;

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.load_start) state_d = LOAD;
      LOAD:    if (exit_load)      state_d = RUN;
      RUN:     if (bus.load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // load_start is ignored while a load is already in progress.
  always_comb begin
    load_ready = (state_q == LOAD);
    start_load = (state_q != LOAD) && bus.load_start;
    beat       = bus.load_valid && load_ready;
    ptr_at_end = (wr_ptr_q == PTR_W'(DEPTH - 1));
    exit_load  = beat && (bus.load_last || ptr_at_end);
  end

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      load_done_q <= 1'b0;
      load_ovf_q  <= 1'b0;
      cpu_run_q   <= 1'b0;
    end else begin
      load_done_q <= exit_load;
      cpu_run_q   <= (state_d == RUN);
      if (start_load) begin
        wr_ptr_q   <= '0;
        prog_len_q <= '0;
        load_ovf_q <= 1'b0;
      end else if (beat) begin
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
        prog_len_q <= prog_len_q + LEN_W'(1);
        if (ptr_at_end && !bus.load_last) begin
          load_ovf_q <= 1'b1;
        end
      end
    end
  end

  instr_mem_array #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_array (
    .clk     (clk_50m),
    .we      (beat),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.load_data),
    .rd_addr (bus.fetch_addr[PTR_W-1:0]),
    .rd_data (rd_data)
  );

  // Addresses at or beyond DEPTH fail the length compare, so the truncated
  // read index never aliases into the visible program.
  assign in_range = (state_q == RUN) && (CMP_W'(bus.fetch_addr) < CMP_W'(prog_len_q));

  assign bus.fetch_instr = in_range ? rd_data : NOP_WORD;
  assign bus.fetch_oob   = !in_range;
  assign bus.load_ready  = load_ready;
  assign bus.load_done   = load_done_q;
  assign bus.load_ovf    = load_ovf_q;
  assign bus.cpu_run     = cpu_run_q;
  assign bus.prog_len    = prog_len_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: fixed fetch table for a known program, randomized stalls and lengths
// checked against a list-of-accepted-words model.
module tb_instr_mem_loader;

  localparam int DEPTH   = 32;
  localparam int INSTR_W = 8;
  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  instr_mem_loader #(
    .INSTR_W  (INSTR_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (8'h00)
  ) dut (
    .clk_50m (clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: the program is simply the ordered list of words that were handshaked.
  logic [7:0] ref_mem [DEPTH];
  int         ref_len = 0;
  bit         ref_run = 1'b0;
  bit         ref_ovf = 1'b0;
  logic [7:0] prog_q [$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] instr;
    logic       oob;
  } fvec_t;
  fvec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sweep_fetch(input string tag);
    logic [7:0] exp_instr;
    bit         exp_oob;
    for (int a = 0; a < 256; a++) begin
      bus.fetch_addr = 8'(a);
      exp_oob   = !(ref_run && (a < ref_len));
      exp_instr = 8'h00;
      if (!exp_oob) exp_instr = ref_mem[a];
      @(negedge clk);
      chk({tag, " fetch_instr"}, 32'(bus.fetch_instr), 32'(exp_instr));
      chk({tag, " fetch_oob"}, 32'(bus.fetch_oob), 32'(exp_oob));
    end
  endtask

  // Offers prog_q with random valid gaps; 'extra' more words are pushed after exit.
  task automatic do_load(input int valid_pct, input bit use_last, input int extra);
    int idx    = 0;
    int cycles = 0;
    bit done   = 1'b0;
    bit v;
    bit last_f;
    bus.load_start = 1'b1;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    ref_run = 1'b0;
    ref_len = 0;
    ref_ovf = 1'b0;
    chk("enter cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("enter prog_len", 32'(bus.prog_len), 32'd0);
    chk("enter load_ovf", 32'(bus.load_ovf), 32'd0);
    chk("enter load_done", 32'(bus.load_done), 32'd0);
    while (!done && cycles < 1000) begin
      cycles++;
      v      = ($urandom_range(99) < valid_pct) && (idx < prog_q.size());
      last_f = use_last && (idx == prog_q.size() - 1);
      bus.load_valid = v;
      bus.load_data  = v ? prog_q[idx] : 8'($urandom);
      bus.load_last  = v ? last_f : 1'($urandom_range(1));
      bus.fetch_addr = 8'($urandom_range(DEPTH - 1));
      #1;
      chk("load_ready in LOAD", 32'(bus.load_ready), 32'd1);
      chk("fetch_oob in LOAD", 32'(bus.fetch_oob), 32'd1);
      @(posedge clk); #1;
      if (v) begin
        ref_mem[ref_len] = prog_q[idx];
        ref_len++;
        idx++;
        if (last_f || ref_len == DEPTH) begin
          done    = 1'b1;
          ref_run = 1'b1;
          ref_ovf = !last_f;
        end
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      chk("load_done", 32'(bus.load_done), 32'(done));
      chk("cpu_run", 32'(bus.cpu_run), 32'(done));
      chk("prog_len", 32'(bus.prog_len), 32'(ref_len));
      chk("load_ovf", 32'(bus.load_ovf), 32'(ref_ovf));
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL load timeout: got no exit after %0d cycles, expected exit", cycles);
    end
    for (int k = 0; k < extra; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = prog_q[idx + k];
      bus.load_last  = 1'b0;
      #1;
      chk("post-exit load_ready", 32'(bus.load_ready), 32'd0);
      @(posedge clk); #1;
      chk("post-exit prog_len", 32'(bus.prog_len), 32'(ref_len));
      chk("post-exit load_done", 32'(bus.load_done), 32'd0);
    end
    bus.load_valid = 1'b0;
    @(posedge clk); #1;
    chk("done pulse width", 32'(bus.load_done), 32'd0);
    chk("cpu_run held", 32'(bus.cpu_run), 32'd1);
  endtask

  initial begin
    tbl[0] = '{8'd3,   8'hA9, 1'b0};
    tbl[1] = '{8'd11,  8'hC2, 1'b0};
    tbl[2] = '{8'd12,  8'h00, 1'b1};
    tbl[3] = '{8'd0,   8'h49, 1'b0};
    tbl[4] = '{8'd9,   8'h00, 1'b0};
    tbl[5] = '{8'd10,  8'h45, 1'b0};
    tbl[6] = '{8'd31,  8'h00, 1'b1};
    tbl[7] = '{8'd255, 8'h00, 1'b1};

    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;
    bus.fetch_addr = 8'h00;

    #23;
    chk("reset cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("reset load_ready", 32'(bus.load_ready), 32'd0);
    chk("reset load_done", 32'(bus.load_done), 32'd0);
    chk("reset load_ovf", 32'(bus.load_ovf), 32'd0);
    chk("reset prog_len", 32'(bus.prog_len), 32'd0);
    rst_n = 1'b1;
    sweep_fetch("idle");

    // Known 12-word program, no stalls.
    prog_q = '{8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D, 8'h49, 8'h18, 8'hA9, 8'h4D, 8'h00, 8'h45, 8'hC2};
    do_load(100, 1'b1, 0);
    chk("12w prog_len", 32'(bus.prog_len), 32'd12);
    for (int i = 0; i < 8; i++) begin
      bus.fetch_addr = tbl[i].addr;
      #1;
      chk($sformatf("tbl[%0d] fetch_instr", i), 32'(bus.fetch_instr), 32'(tbl[i].instr));
      chk($sformatf("tbl[%0d] fetch_oob", i), 32'(bus.fetch_oob), 32'(tbl[i].oob));
    end
    sweep_fetch("prog12");

    // Random lengths with random valid stalls, each reloading from RUN.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      prog_q.delete();
      for (int k = 0; k < n; k++) prog_q.push_back(8'($urandom));
      do_load(40, 1'b1, 0);
      sweep_fetch($sformatf("rand%0d", r));
    end

    // 40 words with no load_last: capacity exit after 32.
    prog_q.delete();
    for (int k = 0; k < 40; k++) prog_q.push_back(8'($urandom));
    do_load(70, 1'b0, 8);
    chk("ovf sticky", 32'(bus.load_ovf), 32'd1);
    chk("ovf prog_len", 32'(bus.prog_len), 32'd32);
    sweep_fetch("ovf");

    // Reload of 4 words clears ovf; address 4 reads NOP.
    prog_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(100, 1'b1, 0);
    chk("reload load_ovf", 32'(bus.load_ovf), 32'd0);
    bus.fetch_addr = 8'd4;
    #1;
    chk("reload addr4 instr", 32'(bus.fetch_instr), 32'h00);
    chk("reload addr4 oob", 32'(bus.fetch_oob), 32'd1);
    bus.fetch_addr = 8'd3;
    #1;
    chk("reload addr3 instr", 32'(bus.fetch_instr), 32'h44);

    // Reset mid-load after 5 beats.
    bus.load_start = 1'b1;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'($urandom);
      bus.load_last  = 1'b0;
      @(posedge clk); #1;
    end
    chk("pre-reset prog_len", 32'(bus.prog_len), 32'd5);
    #2;
    rst_n = 1'b0;
    ref_run = 1'b0;
    ref_len = 0;
    ref_ovf = 1'b0;
    #1;
    chk("async reset load_ready", 32'(bus.load_ready), 32'd0);
    chk("async reset prog_len", 32'(bus.prog_len), 32'd0);
    chk("async reset cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("async reset load_done", 32'(bus.load_done), 32'd0);
    bus.load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post-reset load_done", 32'(bus.load_done), 32'd0);
      chk("post-reset load_ready", 32'(bus.load_ready), 32'd0);
    end
    sweep_fetch("after reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
